fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the asynchronous instruction memory and drives its word address.
- It holds the program counter, reads the combinational instruction word, and registers {instr, pc, pc+4} into a one-entry output stage with a valid/ready handshake to decode.
- It supports redirects (branch/jump) with flush, back-pressure stall, and a halt state entered on a sentinel instruction word.

Parameters:
- S, 32, instruction width in bits; equals the instruction memory data width.
- L, 256, number of instruction memory words; address width AW = $clog2(L).
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] must be 0.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  AW  word address to instruction memory; combinational, equals pc[AW+1:2].
- imem_data  input  S  instruction word from memory, valid in the same cycle as imem_addr.
- redirect_valid  input  1  take redirect this cycle.
- redirect_target  input  32  byte address of the redirect target.
- out_valid  output  1  output stage holds a valid instruction.
- out_ready  input  1  decode accepts the output stage this cycle.
- out_instr  output  S  registered instruction.
- out_pc  output  32  byte address of out_instr.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- halted  output  1  high while the FSM is in HALT.

Behaviour:
- Reset (asynchronous assert, any cycle, including mid-operation):
  - pc = RESET_PC; out_valid = 0; out_instr = 0; out_pc = 0; out_pc_plus4 = 0; halted = 0; state = BOOT.
  - Deassertion is sampled synchronously.
- FSM states:
  - BOOT: no capture and no pc change for exactly one cycle after reset release; then go to RUN.
  - RUN: normal fetch.
  - HALT: no capture and pc frozen; halted = 1.
- Accept condition: acc = out_valid & out_ready. Capture condition in RUN: cap = ~out_valid | out_ready.
- RUN with cap and no redirect:
  - out_instr <= imem_data; out_pc <= pc; out_pc_plus4 <= pc+4; out_valid <= 1; pc <= pc+4.
  - If imem_data == HALT_WORD, the word is still captured and presented, pc is not advanced, and next state = HALT.
- RUN with ~cap (stall): all output registers and pc hold; out_valid stays 1. imem_addr keeps pointing at pc.
- Redirect (has priority over capture, stall and halt detection, in any state except BOOT):
  - pc <= {redirect_target[31:2], 2'b00}; misaligned low bits are silently dropped.
  - out_valid <= 0 (flush, even if out_ready = 0); next state = RUN.
  - The redirect cycle itself captures nothing; the first target instruction appears with out_valid = 1 one cycle later.
  - In BOOT a redirect is ignored.
- HALT:
  - The output stage drains normally: out_valid falls once acc occurs.
  - Only a redirect or reset leaves HALT.
- Latency: imem_addr to out_instr is 1 cycle; redirect to first valid target is 2 edges.
- Throughput: 1 instruction/cycle when out_ready is held at 1.
- Wrap-around:
  - pc increments modulo 2^32.
  - imem_addr truncates, so byte address 4*L aliases to word 0. pc = 32'hFFFF_FFFC wraps to 0. No error flag.
- Simultaneous redirect_valid and out_ready: redirect wins; the held instruction is accepted by decode that cycle and not replayed.

Test Plan:
- Reset, then memory words 0..3 = 0x11,0x22,0x33,0x44 with out_ready=1 -> BOOT lasts 1 cycle; then out_instr = 0x11,0x22,0x33 on consecutive cycles, with out_pc = 0,4,8 and out_pc_plus4 = 4,8,12.
- Hold out_ready=0 for 3 cycles while out_instr=0x22 -> out_instr/out_pc stay 0x22/4 and imem_addr stays 2; after release, 0x33 follows next cycle with no loss or duplicate.
- Redirect to 0x0000_0013 while stalled with valid data -> next cycle out_valid=0 and pc=0x10; the following cycle out_instr=mem[4] with out_pc=0x10.
- mem[5]=0xFFFF_FFFF -> it is presented with out_pc=0x14; then halted=1 and no further captures; after acc, out_valid=0; redirect to 0 -> halted=0 and fetch resumes from mem[0].
- pc=0x3FC with L=256 -> fetches mem[255], then imem_addr=0 with out_pc=0x400.
- rst_n asserted low between clock edges mid-stream -> all outputs zero immediately, pc=RESET_PC, and the BOOT cycle repeats after release.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. It holds the PC, reads asynchronous
//             instruction memory and registers {instr, pc, pc+4} into a
//             one-entry valid/ready output stage. It supports redirect and halt.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int           S         = 32,
    parameter int           L         = 256,
    parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [S-1:0] HALT_WORD = 32'hFFFF_FFFF,
    localparam int          AW        = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] imem_addr,
    input  logic [S-1:0]  imem_data,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [S-1:0]  out_instr,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pc_plus4,
    output logic          halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_valid, w_valid_nxt;
    logic [S-1:0] r_instr, w_instr_nxt;
    logic [31:0]  r_opc, w_opc_nxt;
    logic [31:0]  r_opc4, w_opc4_nxt;
    logic         w_acc, w_cap;
    logic         w_unused_bits;

    assign w_acc         = r_valid & out_ready;
    assign w_cap         = ~r_valid | out_ready;
    // Misaligned target bits are dropped on purpose.
    assign w_unused_bits = ^redirect_target[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_opc   <= '0;
            r_opc4  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_opc   <= w_opc_nxt;
            r_opc4  <= w_opc4_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_opc_nxt   = r_opc;
        w_opc4_nxt  = r_opc4;

        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_cap) begin
                    w_instr_nxt = imem_data;
                    w_opc_nxt   = r_pc;
                    w_opc4_nxt  = r_pc + 32'd4;
                    w_valid_nxt = 1'b1;
                    if (imem_data == HALT_WORD) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            ST_HALT: begin
                if (w_acc) begin
                    w_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        // A redirect overrides capture, stall and halt detection; it flushes the stage.
        if (redirect_valid && (r_state != ST_BOOT)) begin
            w_pc_nxt    = {redirect_target[31:2], 2'b00};
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_RUN;
            w_instr_nxt = r_instr;
            w_opc_nxt   = r_opc;
            w_opc4_nxt  = r_opc4;
        end
    end

    assign imem_addr    = r_pc[AW+1:2];
    assign out_valid    = r_valid;
    assign out_instr    = r_instr;
    assign out_pc       = r_opc;
    assign out_pc_plus4 = r_opc4;
    assign halted       = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. It applies a directed vector
//             table, corner sequences and a randomized run against a model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int          S    = 32;
    localparam int          L    = 256;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;

    logic [31:0] mem [L];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit #(.S(S), .L(L), .RESET_PC(32'h0), .HALT_WORD(HALT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .halted          (halted)
    );

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] ep4;
        logic        eh;
        logic [7:0]  ea;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(logic rv, logic [31:0] tgt, logic rdy, logic ev,
                                logic [31:0] ei, logic [31:0] ep, logic [31:0] ep4,
                                logic eh, logic [7:0] ea);
        vec_t v;
        v.rv = rv; v.tgt = tgt; v.rdy = rdy; v.ev = ev; v.ei = ei;
        v.ep = ep; v.ep4 = ep4; v.eh = eh; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ei,
                             input logic [31:0] ep, input logic [31:0] ep4,
                             input logic eh, input logic [7:0] ea);
        chk({tag, ".valid"},  {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".instr"},  out_instr, ei);
        chk({tag, ".pc"},     out_pc, ep);
        chk({tag, ".pc4"},    out_pc_plus4, ep4);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
        chk({tag, ".addr"},   {24'd0, imem_addr}, {24'd0, ea});
    endtask

    // Behavioural reference: a queue-free cycle model from the fetch rules.
    bit          m_boot, m_halt, m_v;
    logic [31:0] m_pc, m_i, m_p, m_p4;

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_v = 0;
        m_pc = 32'h0; m_i = 0; m_p = 0; m_p4 = 0;
    endtask

    task automatic model_step(input logic rv, input logic [31:0] tgt, input logic rdy);
        logic [31:0] w;
        if (m_boot) begin
            m_boot = 0;
        end else if (rv) begin
            m_pc   = tgt & 32'hFFFF_FFFC;
            m_v    = 0;
            m_halt = 0;
        end else if (!m_halt) begin
            if (!m_v || rdy) begin
                w    = mem[(m_pc / 4) % L];
                m_i  = w;
                m_p  = m_pc;
                m_p4 = m_pc + 32'd4;
                m_v  = 1;
                if (w == HALT) m_halt = 1;
                else           m_pc = m_pc + 32'd4;
            end
        end else if (m_v && rdy) begin
            m_v = 0;
        end
    endtask

    initial begin
        logic [7:0] a;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        out_ready = 1'b0;
        for (int i = 0; i < L; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[4] = 32'h55; mem[5] = HALT;   mem[255] = 32'hABCD_0255;

        //            rv  tgt           rdy ev  instr        pc           pc+4         h  addr
        vt[0]  = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,       32'h0,       0, 8'd0);
        vt[1]  = mk(0, 32'h0,        1, 1, 32'h11,       32'h0,       32'h4,       0, 8'd1);
        vt[2]  = mk(0, 32'h0,        1, 1, 32'h22,       32'h4,       32'h8,       0, 8'd2);
        vt[3]  = mk(0, 32'h0,        0, 1, 32'h22,       32'h4,       32'h8,       0, 8'd2);
        vt[4]  = mk(0, 32'h0,        0, 1, 32'h22,       32'h4,       32'h8,       0, 8'd2);
        vt[5]  = mk(0, 32'h0,        0, 1, 32'h22,       32'h4,       32'h8,       0, 8'd2);
        vt[6]  = mk(0, 32'h0,        1, 1, 32'h33,       32'h8,       32'hC,       0, 8'd3);
        vt[7]  = mk(0, 32'h0,        0, 1, 32'h33,       32'h8,       32'hC,       0, 8'd3);
        vt[8]  = mk(1, 32'h13,       0, 0, 32'h33,       32'h8,       32'hC,       0, 8'd4);
        vt[9]  = mk(0, 32'h0,        1, 1, 32'h55,       32'h10,      32'h14,      0, 8'd5);
        vt[10] = mk(0, 32'h0,        1, 1, HALT,         32'h14,      32'h18,      1, 8'd5);
        vt[11] = mk(0, 32'h0,        0, 1, HALT,         32'h14,      32'h18,      1, 8'd5);
        vt[12] = mk(0, 32'h0,        1, 0, HALT,         32'h14,      32'h18,      1, 8'd5);
        vt[13] = mk(0, 32'h0,        1, 0, HALT,         32'h14,      32'h18,      1, 8'd5);
        vt[14] = mk(1, 32'h0,        0, 0, HALT,         32'h14,      32'h18,      0, 8'd0);
        vt[15] = mk(0, 32'h0,        1, 1, 32'h11,       32'h0,       32'h4,       0, 8'd1);
        vt[16] = mk(1, 32'h3FC,      1, 0, 32'h11,       32'h0,       32'h4,       0, 8'd255);
        vt[17] = mk(0, 32'h0,        1, 1, 32'hABCD_0255, 32'h3FC,    32'h400,     0, 8'd0);
        vt[18] = mk(0, 32'h0,        1, 1, 32'h11,       32'h400,     32'h404,     0, 8'd1);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 32'h0, 32'h0, 32'h0, 0, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            redirect_valid  = vt[i].rv;
            redirect_target = vt[i].tgt;
            out_ready       = vt[i].rdy;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vt[i].ev, vt[i].ei, vt[i].ep,
                      vt[i].ep4, vt[i].eh, vt[i].ea);
        end

        // Asynchronous reset between edges, then the BOOT cycle must repeat.
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 0, 32'h0, 32'h0, 32'h0, 0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_all("reboot", 0, 32'h0, 32'h0, 32'h0, 0, 8'd0);
        @(posedge clk);
        #1 check_all("refetch", 1, 32'h11, 32'h0, 32'h4, 0, 8'd1);

        // Randomized run against the model.
        for (int i = 0; i < L; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                a = m_pc[9:2];
                check_all("rnd_rst", m_v, m_i, m_p, m_p4, m_halt, a);
                @(negedge clk);
                rst_n = 1'b1;
            end
            redirect_valid  = ($urandom_range(0, 99) < 8);
            redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                           : $urandom;
            out_ready       = ($urandom_range(0, 99) < 70);
            model_step(redirect_valid, redirect_target, out_ready);
            @(posedge clk);
            #1;
            a = m_pc[9:2];
            check_all("rnd", m_v, m_i, m_p, m_p4, m_halt, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
